rr_arbiter_n: RTL and testbench
===============================

# rr_arbiter_n

Parametrised N-requester arbiter with registered one-hot grants, grant locking, a hold-time limit and a runtime-selectable fixed-priority or round-robin policy. It is the next generation of the team's 4-requester arbiter and sits between shared-resource clients and the resource they share, such as a bus or memory port. Only one grant is ever asserted. The owner keeps the grant until it releases its request or exceeds the hold limit.

## Interface
- N, default 4: number of requesters, 2..16.
- MAX_HOLD, default 8: maximum consecutive grant cycles per ownership. 0 means unlimited.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  arbitration policy: 0 = fixed priority (req[0] highest), 1 = round-robin.
- req  in  N  request vector, level-sensitive; bit i is requester i.
- gnt  out  N  registered one-hot grant; all zero when idle.
- gnt_valid  out  1  high when any gnt bit is set (equals OR of gnt).
- gnt_id  out  clog2(N)  index of the granted requester. Valid only when gnt_valid is high; otherwise 0.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - Round-robin pointer ptr, clog2(N) bits.
  - Hold counter hcnt, wide enough for MAX_HOLD.
- Arbitration function, given a candidate set C:
  - mode=0: lowest set index in C wins.
  - mode=1: first set index in C at or after ptr, searching upward and wrapping N-1 to 0.
  - mode is sampled only on edges where arbitration occurs.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, winner w = arbitrate(req). Register gnt=1<<w and gnt_id=w, set hcnt=1, set ptr=(w+1) mod N, go to GRANT.
- GRANT, owner o. Conditions are evaluated on each edge in priority order:
  1. req[o]==0 (release) and other requests pending: arbitrate over req and hand over on the same edge (no idle bubble). Apply the IDLE update rules to the new winner.
  2. req[o]==0 and req==0: clear gnt and go to IDLE.
  3. MAX_HOLD!=0 and hcnt==MAX_HOLD and req[o]==1 (timeout):
     - If req & ~(1<<o) is nonzero, arbitrate over that set, excluding the owner for this decision only. Hand over and apply the IDLE update rules.
     - Otherwise o keeps the grant and hcnt restarts at 1. ptr is unchanged.
  4. Otherwise hold: gnt unchanged, hcnt increments.
- hcnt saturates at MAX_HOLD. When MAX_HOLD=0, hcnt is don't-care and timeout never fires.
- ptr updates only on a new grant, never on a hold or a lone-requester restart. In mode=0, ptr still updates but has no effect.
- Requests from non-owners never disturb an active grant except through timeout.

## Timing
- Grant latency: 1 cycle. A req sampled on edge k produces gnt visible after edge k.
- Release-to-handoff: 1 cycle. The owner drops req before edge k; the new gnt is visible after edge k.
- Maximum continuous ownership when others are waiting: MAX_HOLD cycles.
- Worst-case wait, round-robin with all requesters holding: (N-1)*MAX_HOLD cycles.
- Reset, on any edge with rst=1 regardless of req or state:
  - gnt=0, gnt_valid=0, gnt_id=0.
  - ptr=0, hcnt=0, FSM=IDLE.
  - Reset mid-grant drops the grant on that edge.
  - The first arbitration occurs on the first edge with rst=0.
- gnt, gnt_valid and gnt_id are register outputs with no combinational path from req or mode.

## Test plan
All scenarios use N=4 and MAX_HOLD=4.
1. Reset: hold rst=1 for 3 cycles with req=4'b1111 → gnt=0000, gnt_valid=0, gnt_id=0 throughout. First edge with rst=0 and mode=1 → gnt=0001, gnt_id=0.
2. Round-robin rotation: mode=1, req=1111 held → gnt 0001 ×4, 0010 ×4, 0100 ×4, 1000 ×4, then 0001 again. Never more than one bit set; gnt_valid stays 1.
3. Release handoff: mode=1, req=0001 is granted. The owner drops req0 and raises req2 in the same cycle → next edge gnt=0100, with no cycle of gnt=0000. Then req=0000 → next edge gnt=0000 and gnt_valid=0.
4. Fixed-priority timeout exclusion: mode=0, req=1110 held → gnt 0010 ×4, then 0100 ×4 (owner excluded), then 0010 ×4, repeating. Requester 3 is never granted.
5. Lone requester: mode=1, req=0100 held for 12 cycles → gnt=0100 continuously with no gap. ptr remains 3, so a later req=1001 grants 1000 first.
6. Reset mid-grant: gnt=0010 held for 2 cycles, rst pulsed for 1 cycle with req=1111 → gnt=0000 after the reset edge. The next edge grants 0001 (ptr back to 0).

Source files
------------

// File: rtl/rr_arbiter_n.sv
// ---------------------------------------------------------------------------
// rr_arbiter_n
//
// N-requester arbiter with registered one-hot grants. A granted requester
// keeps ownership until it drops its request or, when others are waiting,
// until it has held the grant for MAX_HOLD consecutive cycles. The policy
// is selectable at runtime: fixed priority (req[0] highest) or round-robin
// starting from the requester after the most recent new grant.
//
// Parameters:
//   N         number of requesters, 2..16
//   MAX_HOLD  maximum consecutive grant cycles per ownership, 0 = unlimited
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   mode       0 = fixed priority, 1 = round-robin (sampled when arbitrating)
//   req        level-sensitive request vector, bit i is requester i
//   gnt        registered one-hot grant, all zero when idle
//   gnt_valid  registered, high whenever any gnt bit is set
//   gnt_id     registered index of the granted requester, 0 when idle
// ---------------------------------------------------------------------------
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            valid_q, valid_d;
    logic [IW-1:0]   id_q, id_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;

    logic [N-1:0]    cand;
    logic            cand_any;
    logic [IW-1:0]   winner;
    logic            owner_req;
    logic            timeout;
    logic            do_grant;

    // Returns the first set index of cand. In round-robin the search starts
    // at start and wraps N-1 -> 0; in fixed priority it starts at 0.
    function automatic logic [IW-1:0] arbitrate(
        input logic [N-1:0]  set,
        input logic          rr,
        input logic [IW-1:0] start
    );
        logic [IW-1:0] win;
        logic          found;
        int            idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = rr ? int'(start) + k : k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && set[idx[IW-1:0]]) begin
                win   = idx[IW-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // The owner is excluded from every decision it can lose: on release its
    // request is already low, and on timeout it must be skipped. In IDLE
    // gnt_q is zero, so the mask is a no-op. One arbiter covers all cases.
    assign cand      = req & ~gnt_q;
    assign cand_any  = |cand;
    assign winner    = arbitrate(cand, mode, ptr_q);
    assign owner_req = |(req & gnt_q);
    assign timeout   = (MAX_HOLD != 0) && (hcnt_q == HW'(MAX_HOLD));

    // NOTE: every variable assigned here gets its hold value first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        hcnt_d   = hcnt_q;
        do_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (cand_any) begin
                    do_grant = 1'b1;
                end
            end

            GRANT: begin
                if (!owner_req) begin
                    // Release: hand over on the same edge, or go idle.
                    if (cand_any) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        id_d    = '0;
                        hcnt_d  = '0;
                    end
                end else if (timeout) begin
                    // A lone owner restarts its hold window; ptr stays put.
                    if (cand_any) begin
                        do_grant = 1'b1;
                    end else begin
                        hcnt_d = HW'(1);
                    end
                end else if ((MAX_HOLD != 0) && (hcnt_q != HW'(MAX_HOLD))) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                id_d    = '0;
            end
        endcase

        if (do_grant) begin
            state_d = GRANT;
            gnt_d   = {{(N-1){1'b0}}, 1'b1} << winner;
            id_d    = winner;
            hcnt_d  = HW'(1);
            ptr_d   = (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
        end

        valid_d = |gnt_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = valid_q;
    assign gnt_id    = id_q;

    // Structural invariants of the registered outputs.
    a_onehot : assert property (@(posedge clk) $onehot0(gnt_q));
    a_valid  : assert property (@(posedge clk) valid_q == (|gnt_q));
    a_id     : assert property (@(posedge clk) valid_q |-> gnt_q[id_q]);
    a_idle_id: assert property (@(posedge clk) !valid_q |-> (id_q == '0));

endmodule

// File: tb/tb_rr_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_n
//
// Scoreboard bench for rr_arbiter_n with N=4, MAX_HOLD=4. The stimulus
// process drives inputs on the falling edge, advances a behavioural model
// of the arbiter and queues the grant expected after the next rising edge.
// A monitor process samples the DUT just after each rising edge, pops the
// queue and compares. Directed scenarios are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_n;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IW       = 2;

    logic          clk = 1'b1;
    logic          rst;
    logic          mode;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;

    always #5 clk = ~clk;

    rr_arbiter_n #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    typedef struct {
        logic [N-1:0]  gnt;
        logic          valid;
        logic [IW-1:0] id;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Owner is a requester number or -1 when nobody holds the grant;
    // held counts cycles of the current ownership.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;

    function automatic bit has(input logic [N-1:0] set, input int i);
        logic [N-1:0] s;
        s = set >> i;
        return s[0];
    endfunction

    function automatic int pick(input logic [N-1:0] set, input logic rr);
        int i;
        for (int k = 0; k < N; k++) begin
            i = rr ? (m_ptr + k) % N : k;
            if (has(set, i)) return i;
        end
        return -1;
    endfunction

    function automatic void take(input int w);
        m_owner = w;
        m_held  = 1;
        m_ptr   = (w + 1) % N;
    endfunction

    function automatic void model_step(input logic r, input logic md, input logic [N-1:0] rq);
        logic [N-1:0] others;
        if (r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            if (rq != 0) take(pick(rq, md));
        end else if (!has(rq, m_owner)) begin
            if (rq != 0) take(pick(rq, md));
            else m_owner = -1;
        end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
            others = rq & ~(N'(1) << m_owner);
            if (others != 0) take(pick(others, md));
            else m_held = 1;
        end else if (m_held < MAX_HOLD) begin
            m_held++;
        end
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic md, input logic [N-1:0] rq, input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            rst  = r;
            mode = md;
            req  = rq;
            model_step(r, md, rq);
            cyc++;
            e.gnt   = (m_owner < 0) ? '0 : N'(1) << m_owner;
            e.valid = (m_owner >= 0);
            e.id    = (m_owner < 0) ? '0 : IW'(m_owner);
            e.cyc   = cyc;
            exp_q.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            end else begin
                e = exp_q.pop_front();
                check($sformatf("gnt@%0d", e.cyc), 32'(gnt), 32'(e.gnt));
                check($sformatf("gnt_valid@%0d", e.cyc), 32'(gnt_valid), 32'(e.valid));
                check($sformatf("gnt_id@%0d", e.cyc), 32'(gnt_id), 32'(e.id));
            end
        end
    end

    initial begin
        logic          r;
        logic          md;
        logic [N-1:0]  rq;

        // Reset with all requesting, then round-robin rotation.
        drive(1'b1, 1'b1, 4'b1111, 3);
        drive(1'b0, 1'b1, 4'b1111, 20);

        // Release handoff with no idle bubble, then go idle.
        drive(1'b1, 1'b1, 4'b0000, 1);
        drive(1'b0, 1'b1, 4'b0001, 2);
        drive(1'b0, 1'b1, 4'b0100, 2);
        drive(1'b0, 1'b1, 4'b0000, 2);

        // Fixed-priority timeout with owner exclusion.
        drive(1'b1, 1'b0, 4'b0000, 1);
        drive(1'b0, 1'b0, 4'b1110, 26);

        // Lone requester keeps the grant; ptr then favours requester 3.
        drive(1'b1, 1'b1, 4'b0000, 1);
        drive(1'b0, 1'b1, 4'b0100, 12);
        drive(1'b0, 1'b1, 4'b1001, 3);

        // Reset in the middle of a grant.
        drive(1'b1, 1'b1, 4'b0000, 1);
        drive(1'b0, 1'b1, 4'b0010, 3);
        drive(1'b1, 1'b1, 4'b1111, 1);
        drive(1'b0, 1'b1, 4'b1111, 2);

        // Random traffic with requests held for a few cycles at a time.
        md = 1'b1;
        rq = '0;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 31) == 0) md = ~md;
            if ($urandom_range(0, 3) == 0) begin
                rq = ($urandom_range(0, 3) == 0) ? 4'b1111 : N'($urandom_range(0, 15));
            end
            drive(r, md, rq, 1);
        end

        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
